alu_arbiter_ctrl: RTL and testbench

//  Shares one combinational 64-bit ALU (4-bit ALUctl, A/B in, ALUOut/Zero out) between two requesters.

---
 rtl/alu_arbiter_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_alu_arbiter_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_arbiter_ctrl
// Description : Round-robin front end that shares one combinational ALU
//               between two valid/ready requesters. Operands are held for a
//               per-op multicycle window (MUL/DIV) and the result is returned
//               through a registered, backpressured response port.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_arbiter_ctrl #(
  parameter int WIDTH      = 64,
  parameter int MUL_CYCLES = 3,
  parameter int DIV_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_ctl,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_ctl,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [3:0]       alu_ctl,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_zero,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic             busy
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  // Counter runs 0..N-1, so it only needs to hold MAX_CYC-1.
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

  localparam logic [1:0] C_IDLE = 2'd0;
  localparam logic [1:0] C_EXEC = 2'd1;
  localparam logic [1:0] C_RESP = 2'd2;

  localparam logic [3:0] C_OP_BAD = 4'b1000;
  localparam logic [3:0] C_OP_MUL = 4'b1110;
  localparam logic [3:0] C_OP_DIV = 4'b1111;

  localparam logic [CNT_W-1:0] C_MUL_LAST = CNT_W'(MUL_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_DIV_LAST = CNT_W'(DIV_CYCLES - 1);

  logic [1:0]       state_q, state_d;
  logic             prio_q, prio_d;     // 0: req0 wins a tie, 1: req1 wins
  logic             id_q, id_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_zero_q, rsp_zero_d;
  logic             rsp_err_q, rsp_err_d;

  logic             w_idle;
  logic             w_grant0;
  logic             w_grant1;
  logic             w_accept;
  logic             w_err_op;
  logic [CNT_W-1:0] w_last_cnt;
  logic             w_exec_done;

  // Round-robin grant; ready is forced low while reset is asserted.
  always_comb begin
    w_idle   = (state_q == C_IDLE) && !rst;
    w_grant0 = w_idle && req0_valid && (!req1_valid || !prio_q);
    w_grant1 = w_idle && req1_valid && (!req0_valid ||  prio_q);
    w_accept = w_grant0 || w_grant1;
  end

  // Error detection and per-op EXEC length; errors short-circuit to one cycle.
  always_comb begin
    w_err_op = (alu_ctl_q == C_OP_BAD) ||
               ((alu_ctl_q == C_OP_DIV) && (alu_b_q == '0));
    w_last_cnt = '0;
    if (!w_err_op) begin
      if (alu_ctl_q == C_OP_MUL)      w_last_cnt = C_MUL_LAST;
      else if (alu_ctl_q == C_OP_DIV) w_last_cnt = C_DIV_LAST;
    end
    w_exec_done = (state_q == C_EXEC) && (cnt_q == w_last_cnt);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= C_IDLE;
    else     state_q <= state_d;
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      C_IDLE:  if (w_accept)    state_d = C_EXEC;
      C_EXEC:  if (w_exec_done) state_d = C_RESP;
      C_RESP:  if (rsp_ready)   state_d = C_IDLE;
      default:                  state_d = C_IDLE;
    endcase
  end

  // FSM-derived outputs.
  always_comb begin
    req0_ready = w_grant0;
    req1_ready = w_grant1;
    rsp_valid  = (state_q == C_RESP);
    busy       = (state_q != C_IDLE);
  end

  // Datapath next values: capture on accept, count and sample in EXEC.
  always_comb begin
    prio_d     = prio_q;
    id_d       = id_q;
    cnt_d      = cnt_q;
    alu_ctl_d  = alu_ctl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rsp_data_d = rsp_data_q;
    rsp_zero_d = rsp_zero_q;
    rsp_err_d  = rsp_err_q;
    if (w_accept) begin
      id_d      = w_grant1;
      prio_d    = w_grant0;   // loser of this round gets priority next
      cnt_d     = '0;
      alu_ctl_d = w_grant1 ? req1_ctl : req0_ctl;
      alu_a_d   = w_grant1 ? req1_a   : req0_a;
      alu_b_d   = w_grant1 ? req1_b   : req0_b;
    end
    if (state_q == C_EXEC) begin
      if (w_exec_done) begin
        cnt_d     = '0;
        rsp_err_d = w_err_op;
        if (w_err_op) begin
          rsp_data_d = (alu_ctl_q == C_OP_BAD) ? '0 : '1;
          rsp_zero_d = 1'b0;
        end else begin
          rsp_data_d = alu_out;
          rsp_zero_d = alu_zero;
        end
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prio_q     <= 1'b0;
      id_q       <= 1'b0;
      cnt_q      <= '0;
      alu_ctl_q  <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
      rsp_err_q  <= 1'b0;
    end else begin
      prio_q     <= prio_d;
      id_q       <= id_d;
      cnt_q      <= cnt_d;
      alu_ctl_q  <= alu_ctl_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rsp_data_q <= rsp_data_d;
      rsp_zero_q <= rsp_zero_d;
      rsp_err_q  <= rsp_err_d;
    end
  end

  assign alu_ctl  = alu_ctl_q;
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign rsp_id   = id_q;
  assign rsp_data = rsp_data_q;
  assign rsp_zero = rsp_zero_q;
  assign rsp_err  = rsp_err_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_arbiter_ctrl
// Description : Self-checking bench for alu_arbiter_ctrl with a behavioural
//               ALU, a response scoreboard and directed timing checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_arbiter_ctrl;

  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [3:0]       req0_ctl;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  logic [3:0]       req1_ctl;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [3:0]       alu_ctl;
  logic [WIDTH-1:0] alu_a, alu_b, alu_out;
  logic             alu_zero;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err, busy;
  logic [WIDTH-1:0] rsp_data;

  typedef struct {
    logic             id;
    logic [WIDTH-1:0] data;
    logic             zero;
    logic             err;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_arbiter_ctrl #(.WIDTH(WIDTH), .MUL_CYCLES(3), .DIV_CYCLES(8)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_ctl(req0_ctl),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_ctl(req1_ctl),
    .req1_a(req1_a), .req1_b(req1_b),
    .alu_ctl(alu_ctl), .alu_a(alu_a), .alu_b(alu_b),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero), .rsp_err(rsp_err), .busy(busy)
  );

  // Behavioural ALU; unknown codes return a marker so error overrides are visible.
  always_comb begin
    alu_out = 64'hDEAD_BEEF;
    case (alu_ctl)
      4'b0000: alu_out = alu_a & alu_b;
      4'b0001: alu_out = alu_a | alu_b;
      4'b0010: alu_out = alu_a + alu_b;
      4'b0011: alu_out = alu_a ^ alu_b;
      4'b0110: alu_out = alu_a - alu_b;
      4'b0111: alu_out = ($signed(alu_a) < $signed(alu_b)) ? 64'd1 : 64'd0;
      4'b1100: alu_out = ~(alu_a | alu_b);
      4'b1110: alu_out = alu_a * alu_b;
      4'b1111: alu_out = (alu_b == '0) ? 64'd0 : alu_a / alu_b;
      default: alu_out = 64'hDEAD_BEEF;
    endcase
    alu_zero = (alu_out == '0);
  end

  task automatic check(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic id, input logic [WIDTH-1:0] d, input logic z, input logic e);
    exp_t x;
    x.id = id; x.data = d; x.zero = z; x.err = e;
    sb_q.push_back(x);
  endtask

  // Scoreboard: compare every completed response handshake.
  always @(negedge clk) begin : mon
    exp_t x;
    if (!rst && rsp_valid && rsp_ready) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 64'd1, 64'd0);
      end else begin
        x = sb_q.pop_front();
        check("rsp_id",   {63'd0, rsp_id},   {63'd0, x.id});
        check("rsp_data", rsp_data,          x.data);
        check("rsp_zero", {63'd0, rsp_zero}, {63'd0, x.zero});
        check("rsp_err",  {63'd0, rsp_err},  {63'd0, x.err});
      end
    end
  end

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 64) begin
      @(posedge clk); #1;
      k++;
    end
    if (busy) check("idle_timeout", {63'd0, busy}, 64'd0);
  endtask

  // Single requester op: checks grant, operand capture and response latency.
  task automatic issue(input logic id, input logic [3:0] ctl, input logic [WIDTH-1:0] a,
                       input logic [WIDTH-1:0] b, input logic [WIDTH-1:0] exp_d,
                       input logic exp_z, input logic exp_e, input int n);
    int lat = 0;
    if (id) begin req1_ctl = ctl; req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else    begin req0_ctl = ctl; req0_a = a; req0_b = b; req0_valid = 1'b1; end
    @(negedge clk);
    check(id ? "grant1" : "grant0", {63'd0, id ? req1_ready : req0_ready}, 64'd1);
    push_exp(id, exp_d, exp_z, exp_e);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    check("alu_ctl", {60'd0, alu_ctl}, {60'd0, ctl});
    check("alu_a", alu_a, a);
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!rsp_valid && lat < 64);
    check("latency", lat, n);
    check("alu_ctl_hold", {60'd0, alu_ctl}, {60'd0, ctl});
    check("alu_b_hold", alu_b, b);
  endtask

  initial begin
    rst = 1'b1;
    rsp_ready = 1'b1;
    req0_valid = 1'b0; req0_ctl = '0; req0_a = '0; req0_b = '0;
    req1_valid = 1'b0; req1_ctl = '0; req1_a = '0; req1_b = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_alu_ctl", {60'd0, alu_ctl}, 64'd0);
    check("rst_rsp_data", rsp_data, 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous requests: req0 wins, then req1 wins the next tie.
    req0_ctl = 4'b0110; req0_a = 64'd5; req0_b = 64'd2; req0_valid = 1'b1;
    req1_ctl = 4'b0011; req1_a = 64'd7; req1_b = 64'd5; req1_valid = 1'b1;
    @(negedge clk);
    check("tie1_rdy0", {63'd0, req0_ready}, 64'd1);
    check("tie1_rdy1", {63'd0, req1_ready}, 64'd0);
    push_exp(1'b0, 64'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_ctl = 4'b0000; req0_a = 64'd6; req0_b = 64'd3;
    wait_idle();
    @(negedge clk);
    check("tie2_rdy1", {63'd0, req1_ready}, 64'd1);
    check("tie2_rdy0", {63'd0, req0_ready}, 64'd0);
    push_exp(1'b1, 64'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("tie3_rdy0", {63'd0, req0_ready}, 64'd1);
    push_exp(1'b0, 64'd2, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();

    // Single-cycle, multicycle and error ops.
    issue(1'b0, 4'b0010, 64'd1,  64'd2, 64'd3,  1'b0, 1'b0, 1); wait_idle();
    issue(1'b0, 4'b1110, 64'd3,  64'd4, 64'hC,  1'b0, 1'b0, 3); wait_idle();
    issue(1'b0, 4'b1111, 64'hC,  64'd3, 64'd4,  1'b0, 1'b0, 8); wait_idle();
    issue(1'b0, 4'b1111, 64'd5,  64'd0, '1,     1'b0, 1'b1, 1); wait_idle();
    issue(1'b0, 4'b1000, 64'd7,  64'd7, 64'd0,  1'b0, 1'b1, 1); wait_idle();

    // Backpressure: SLT 5,2 held while rsp_ready is low.
    rsp_ready = 1'b0;
    issue(1'b0, 4'b0111, 64'd5, 64'd2, 64'd0, 1'b1, 1'b0, 1);
    req1_ctl = 4'b0001; req1_a = 64'd1; req1_b = 64'd2; req1_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_valid", {63'd0, rsp_valid}, 64'd1);
      check("hold_data", rsp_data, 64'd0);
      check("hold_zero", {63'd0, rsp_zero}, 64'd1);
      check("hold_rdy0", {63'd0, req0_ready}, 64'd0);
      check("hold_rdy1", {63'd0, req1_ready}, 64'd0);
      @(posedge clk); #1;
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    check("resp_no_accept", {63'd0, req1_ready}, 64'd0);
    @(posedge clk); #1;
    check("post_rsp_busy", {63'd0, busy}, 64'd0);
    check("post_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    @(negedge clk);
    check("post_rsp_rdy1", {63'd0, req1_ready}, 64'd1);
    push_exp(1'b1, 64'd3, 1'b0, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a MUL window.
    req0_ctl = 4'b1110; req0_a = 64'd3; req0_b = 64'd4; req0_valid = 1'b1;
    @(negedge clk);
    check("mul_rdy0", {63'd0, req0_ready}, 64'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("arst_alu_ctl", {60'd0, alu_ctl}, 64'd0);
    check("arst_alu_a", alu_a, 64'd0);
    check("arst_rsp_data", rsp_data, 64'd0);
    check("arst_rsp_id", {63'd0, rsp_id}, 64'd0);
    check("arst_rdy0", {63'd0, req0_ready}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("arst_no_rsp", {63'd0, rsp_valid}, 64'd0);
    req0_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;
    issue(1'b1, 4'b0010, 64'd10, 64'd20, 64'd30, 1'b0, 1'b0, 1); wait_idle();

    // Tie after the req1-only op goes to req0.
    req0_ctl = 4'b0001; req0_a = 64'd1; req0_b = 64'd4; req0_valid = 1'b1;
    req1_ctl = 4'b0110; req1_a = 64'd9; req1_b = 64'd9; req1_valid = 1'b1;
    @(negedge clk);
    check("tie4_rdy0", {63'd0, req0_ready}, 64'd1);
    check("tie4_rdy1", {63'd0, req1_ready}, 64'd0);
    push_exp(1'b0, 64'd5, 1'b0, 1'b0);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    wait_idle();
    @(negedge clk);
    check("tie5_rdy1", {63'd0, req1_ready}, 64'd1);
    push_exp(1'b1, 64'd0, 1'b1, 1'b0);
    @(posedge clk); #1;
    req1_valid = 1'b0;
    wait_idle();
    repeat (2) @(posedge clk);
    #1;

    check("sb_drain", sb_q.size(), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
`default_nettype wire
